dram_arbiter: RTL

//  Two-master arbiter and sequencer for the single-port data RAM (RAM_B) behind MIO_BUS.

---
 rtl/dram_arb_pkg.sv | 16 +
 rtl/dram_arb_pick.sv | 28 ++
 rtl/dram_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the RAM_B two-master arbiter.
package dram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic OWN_M0     = 1'b0;
    localparam logic OWN_M1     = 1'b1;
    localparam int   RD_LAT_MAX = 4;
    localparam int   WAIT_CNT_W = 2;

endpackage

// File: rtl/dram_arb_pick.sv
// Combinational grant selection; DRAM_ARB_RR_EN selects round-robin, otherwise master 0 wins ties.
module dram_arb_pick
    import dram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_id
);

`ifdef DRAM_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = OWN_M0;
        if (req0 && req1) begin
            grant_id = RR_EN ? ~last_owner : OWN_M0;
        end else if (req1) begin
            grant_id = OWN_M1;
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Two-master arbiter/sequencer for single-port RAM_B; tie policy set by DRAM_ARB_RR_EN in dram_arb_pick.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req,
    input  logic [DATA_W/8-1:0] m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic                m0_ack,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_req,
    input  logic [DATA_W/8-1:0] m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic                m1_ack,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W/8-1:0] ram_wea,
    output logic [DATA_W-1:0]   ram_dina,
    input  logic [DATA_W-1:0]   ram_douta,
    output logic                busy,
    output logic                owner
);

    localparam int BE_W = DATA_W / 8;

    state_t                  state;
    logic                    last_owner;
    logic [BE_W-1:0]         lat_we;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic                    grant_valid;
    logic                    grant_id;

    dram_arb_pick u_pick (
        .req0        (m0_req),
        .req1        (m1_req),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // RAM drive is registered at the grant edge so it is valid throughout ISSUE;
    // owner doubles as the latched winner for the rest of the access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= OWN_M1;
            owner      <= OWN_M0;
            busy       <= 1'b0;
            lat_we     <= '0;
            wait_cnt   <= '0;
            ram_addr   <= '0;
            ram_wea    <= '0;
            ram_dina   <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner    <= grant_id;
                        busy     <= 1'b1;
                        lat_we   <= (grant_id == OWN_M1) ? m1_we    : m0_we;
                        ram_wea  <= (grant_id == OWN_M1) ? m1_we    : m0_we;
                        ram_addr <= (grant_id == OWN_M1) ? m1_addr  : m0_addr;
                        ram_dina <= (grant_id == OWN_M1) ? m1_wdata : m0_wdata;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_wea <= '0;
                    if ((lat_we != '0) || (RD_LAT == 1)) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= WAIT_CNT_W'(RD_LAT - 2);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (owner == OWN_M1) begin
                        m1_ack <= 1'b1;
                        if (lat_we == '0) m1_rdata <= ram_douta;
                    end else begin
                        m0_ack <= 1'b1;
                        if (lat_we == '0) m0_rdata <= ram_douta;
                    end
                    last_owner <= owner;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
